// File: rtl/slot_arb_pkg.sv
// slot_arb_pkg: shared types, constants and page-field helpers for the slot access arbiter
package slot_arb_pkg;
  typedef enum logic [3:0] {
    IDLE, ARB, SEL_SETUP, SEL_STROBE, SEL_HOLD, ACC_SETUP, ACC_STROBE, ACC_HOLD, DONE
  } state_t;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD} phase_t;
  localparam logic [15:0] SLT_ADDR = 16'hFFFF;
  typedef struct packed {
    logic        sltsl_n;
    logic        merq_n;
    logic        rd_n;
    logic        wr_n;
    logic        cs1_n;
    logic        cs2_n;
    logic        cs12_n;
    logic [15:0] addr;
    logic [7:0]  din;
  } bus_t;
  localparam bus_t BUS_IDLE = bus_t'({7'h7f, 24'h0});
  function automatic logic [1:0] page_get(input logic [7:0] s, input logic [1:0] p);
    return s[{p, 1'b0} +: 2];
  endfunction
  function automatic logic [7:0] page_set(input logic [7:0] s, input logic [1:0] p, input logic [1:0] v);
    logic [7:0] r;
    r = s;
    r[{p, 1'b0} +: 2] = v;
    return r;
  endfunction
endpackage

// File: rtl/bus_if.sv
// BUS_IF: MSX-style slot bus between the arbiter and an expanded slot
interface BUS_IF;
  logic        RESET_n, SLTSL_n, MERQ_n, IORQ_n, RD_n, WR_n;
  logic        CS1_n, CS2_n, CS12_n, M1_n, RFSH_n, WAIT_n;
  logic [15:0] ADDR;
  logic [7:0]  DIN, DOUT;
  modport MSX (
    output RESET_n, SLTSL_n, MERQ_n, IORQ_n, RD_n, WR_n, CS1_n, CS2_n, CS12_n, M1_n, RFSH_n,
    output ADDR, DIN,
    input  DOUT, WAIT_n
  );
endinterface

// File: rtl/slot_bus_cycle.sv
// slot_bus_cycle: one registered setup/strobe/hold slot bus cycle with WAIT_n stretch and timeout
module slot_bus_cycle
  import slot_arb_pkg::*;
#(
  parameter int STROBE_CYC  = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  din_i,
  input  logic        wait_n_i,
  input  logic [7:0]  dout_i,
  output bus_t        bus_o,
  output logic [7:0]  rdata_o,
  output logic        end_o,
  output logic        timeout_o
);
  localparam int CW = 16;
  phase_t phase_q;
  bus_t bus_q;
  logic [CW-1:0] cnt_q;
  logic we_q, ready;
  logic [7:0] rdata_q;
  assign ready = phase_q == PH_STROBE && cnt_q >= CW'(STROBE_CYC - 1);
  assign end_o = ready && wait_n_i;
  // strobe runs STROBE_CYC cycles plus at most TIMEOUT_CYC WAIT_n extensions
  assign timeout_o = ready && !wait_n_i && cnt_q == CW'(STROBE_CYC - 1 + TIMEOUT_CYC);
  assign bus_o = bus_q;
  assign rdata_o = rdata_q;
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      phase_q <= PH_IDLE;
      bus_q <= BUS_IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      rdata_q <= 8'h0;
    end else if (start_i) begin
      phase_q <= PH_SETUP;
      we_q <= we_i;
      cnt_q <= '0;
      bus_q <= '{sltsl_n: 1'b0, merq_n: 1'b0, rd_n: 1'b1, wr_n: 1'b1,
                 cs1_n: addr_i[15:14] != 2'b01, cs2_n: addr_i[15:14] != 2'b10,
                 cs12_n: addr_i[15:14] != 2'b01 && addr_i[15:14] != 2'b10,
                 addr: addr_i, din: we_i ? din_i : 8'h0};
    end else if (phase_q == PH_SETUP) begin
      phase_q <= PH_STROBE;
      bus_q.rd_n <= we_q;
      bus_q.wr_n <= !we_q;
    end else if (timeout_o) begin
      phase_q <= PH_IDLE;
      bus_q <= BUS_IDLE;
      rdata_q <= 8'h0;
    end else if (end_o) begin
      phase_q <= PH_HOLD;
      bus_q.rd_n <= 1'b1;
      bus_q.wr_n <= 1'b1;
      rdata_q <= we_q ? 8'h0 : dout_i;
    end else if (phase_q == PH_STROBE) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (phase_q == PH_HOLD) begin
      phase_q <= PH_IDLE;
      bus_q <= BUS_IDLE;
    end
endmodule

// File: rtl/slot_access_arbiter.sv
// slot_access_arbiter: round-robin two-requester access to an expanded slot with
// automatic secondary-slot select at FFFFh
module slot_access_arbiter
  import slot_arb_pkg::*;
#(
  parameter int STROBE_CYC  = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             RESET_n,
  input  logic             CLK,
  input  logic [1:0]       REQ,
  input  logic [1:0]       WE,
  input  logic [1:0][15:0] ADDR,
  input  logic [1:0][1:0]  SUB,
  input  logic [1:0][7:0]  WDATA,
  output logic [1:0]       ACK,
  output logic [7:0]       RDATA,
  output logic             ERR,
  output logic             BUSY,
  output logic [7:0]       SLTEXP,
  BUS_IF.MSX               Bus
);
  state_t state_q;
  logic ptr_q, gnt_q, we_q, err_q, busy_q, brst_q;
  logic [15:0] addr_q;
  logic [1:0] sub_q, ack_q;
  logic [7:0] wdata_q, sltexp_q, rdata_q;
  logic gnt_d, sel_need, start, cyc_we, cyc_end, cyc_to;
  logic [15:0] cyc_addr;
  logic [7:0] cyc_din, cyc_rdata, sltexp_d;
  bus_t cyc_bus;
  assign gnt_d = &REQ ? ptr_q : REQ[1];
  assign sel_need = ADDR[gnt_d] != SLT_ADDR && page_get(sltexp_q, ADDR[gnt_d][15:14]) != SUB[gnt_d];
  assign sltexp_d = page_set(sltexp_q, addr_q[15:14], sub_q);
  assign start = (state_q == ARB && |REQ) || state_q == SEL_HOLD;
  // ARB launches either the select write or the access; SEL_HOLD launches the access
  assign cyc_we = state_q == SEL_HOLD ? we_q : sel_need | WE[gnt_d];
  assign cyc_addr = state_q == SEL_HOLD ? addr_q : sel_need ? SLT_ADDR : ADDR[gnt_d];
  assign cyc_din = state_q == SEL_HOLD ? wdata_q :
                   sel_need ? page_set(sltexp_q, ADDR[gnt_d][15:14], SUB[gnt_d]) : WDATA[gnt_d];
  slot_bus_cycle #(.STROBE_CYC(STROBE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) u_cyc (
    .CLK(CLK), .RESET_n(RESET_n), .start_i(start), .we_i(cyc_we), .addr_i(cyc_addr),
    .din_i(cyc_din), .wait_n_i(Bus.WAIT_n), .dout_i(Bus.DOUT), .bus_o(cyc_bus),
    .rdata_o(cyc_rdata), .end_o(cyc_end), .timeout_o(cyc_to)
  );
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) brst_q <= 1'b0;
    else brst_q <= 1'b1;
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      gnt_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= 16'h0;
      sub_q <= 2'b0;
      wdata_q <= 8'h0;
      sltexp_q <= 8'h0;
      ack_q <= 2'b0;
      rdata_q <= 8'h0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= |REQ ? ARB : IDLE;
        ARB:
          if (|REQ) begin
            ptr_q <= !gnt_d;
            gnt_q <= gnt_d;
            we_q <= WE[gnt_d];
            addr_q <= ADDR[gnt_d];
            sub_q <= SUB[gnt_d];
            wdata_q <= WDATA[gnt_d];
            busy_q <= 1'b1;
            err_q <= 1'b0;
            state_q <= sel_need ? SEL_SETUP : ACC_SETUP;
          end else state_q <= IDLE;
        SEL_SETUP, ACC_SETUP: state_q <= state_q == SEL_SETUP ? SEL_STROBE : ACC_STROBE;
        SEL_STROBE, ACC_STROBE:
          if (cyc_to) begin
            state_q <= DONE;
            ack_q <= gnt_q ? 2'b10 : 2'b01;
            rdata_q <= 8'h0;
            err_q <= 1'b1;
          end else if (cyc_end) state_q <= state_q == SEL_STROBE ? SEL_HOLD : ACC_HOLD;
        SEL_HOLD: begin
          sltexp_q <= sltexp_d;
          state_q <= ACC_SETUP;
        end
        ACC_HOLD: begin
          if (we_q && addr_q == SLT_ADDR) sltexp_q <= wdata_q;
          rdata_q <= cyc_rdata;
          ack_q <= gnt_q ? 2'b10 : 2'b01;
          state_q <= DONE;
        end
        DONE: begin
          ack_q <= 2'b0;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign ACK = ack_q;
  assign RDATA = rdata_q;
  assign ERR = err_q;
  assign BUSY = busy_q;
  assign SLTEXP = sltexp_q;
  assign Bus.RESET_n = brst_q;
  assign Bus.SLTSL_n = cyc_bus.sltsl_n;
  assign Bus.MERQ_n = cyc_bus.merq_n;
  assign Bus.RD_n = cyc_bus.rd_n;
  assign Bus.WR_n = cyc_bus.wr_n;
  assign Bus.CS1_n = cyc_bus.cs1_n;
  assign Bus.CS2_n = cyc_bus.cs2_n;
  assign Bus.CS12_n = cyc_bus.cs12_n;
  assign Bus.ADDR = cyc_bus.addr;
  assign Bus.DIN = cyc_bus.din;
  assign Bus.IORQ_n = 1'b1;
  assign Bus.M1_n = 1'b1;
  assign Bus.RFSH_n = 1'b1;
endmodule

// File: tb/tb_slot_access_arbiter.sv
// tb_slot_access_arbiter: directed checks of arbitration, slot select, timing, timeout and reset
module tb_slot_access_arbiter;
  logic CLK = 0, RESET_n = 0;
  logic [1:0] REQ = '0, WE = '0;
  logic [1:0][15:0] ADDR = '0;
  logic [1:0][1:0] SUB = '0;
  logic [1:0][7:0] WDATA = '0;
  logic [1:0] ACK;
  logic [7:0] RDATA, SLTEXP;
  logic ERR, BUSY;
  BUS_IF bus();
  logic wait_low = 0;
  logic [7:0] slot_reg = 8'h0;
  assign bus.WAIT_n = !wait_low;
  assign bus.DOUT = bus.ADDR == 16'hFFFF ? ~slot_reg : bus.ADDR[15:8] ^ 8'h5A;
  always #5 CLK = ~CLK;
  slot_access_arbiter dut (
    .RESET_n(RESET_n), .CLK(CLK), .REQ(REQ), .WE(WE), .ADDR(ADDR), .SUB(SUB), .WDATA(WDATA),
    .ACK(ACK), .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY), .SLTEXP(SLTEXP), .Bus(bus)
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic logic [33:0] bus_vec();
    return {bus.SLTSL_n, bus.MERQ_n, bus.RD_n, bus.WR_n, bus.IORQ_n, bus.CS1_n, bus.CS2_n,
            bus.CS12_n, bus.M1_n, bus.RFSH_n, bus.ADDR, bus.DIN};
  endfunction
  localparam logic [33:0] IDLE_VEC = {10'h3FF, 24'h0};
  logic stb, prev_stb = 0;
  int cur_len = 0, last_len = 0;
  logic [15:0] log_addr[$];
  logic [7:0] log_din[$];
  logic log_we[$];
  logic [3:0] log_cs[$];
  assign stb = !bus.RD_n || !bus.WR_n;
  always @(negedge CLK) begin
    if (stb && !prev_stb) begin
      log_addr.push_back(bus.ADDR);
      log_din.push_back(bus.DIN);
      log_we.push_back(!bus.WR_n);
      log_cs.push_back({bus.IORQ_n, bus.CS1_n, bus.CS2_n, bus.CS12_n});
    end
    cur_len <= stb ? cur_len + 1 : 0;
    if (!stb && prev_stb) last_len <= cur_len;
    if (!bus.WR_n && bus.ADDR == 16'hFFFF) slot_reg <= bus.DIN;
    prev_stb <= stb;
  end
  task automatic do_req(input int r, input logic we, input logic [15:0] a, input logic [1:0] s,
                        input logic [7:0] d, output int lat, output logic [7:0] rd,
                        output logic er, output logic [1:0] ak);
    @(negedge CLK);
    WE[r] = we; ADDR[r] = a; SUB[r] = s; WDATA[r] = d; REQ[r] = 1'b1;
    lat = 0; ak = 2'b0;
    while (ak == 2'b0 && lat < 1000) begin
      @(posedge CLK); #1;
      lat++;
      ak = ACK;
    end
    rd = RDATA; er = ERR; REQ[r] = 1'b0;
    chk("ack_seen", ak != 2'b0, 1);
    @(posedge CLK); #1;
    chk("ack_pulse", ACK, 2'b0);
  endtask
  initial begin
    int lat, base, cnt;
    logic [7:0] rd;
    logic er, found;
    logic [1:0] ak, seen;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ack", ACK, 0); chk("rst_rdata", RDATA, 0); chk("rst_err", ERR, 0);
    chk("rst_busy", BUSY, 0); chk("rst_sltexp", SLTEXP, 0);
    chk("rst_bus", bus_vec(), IDLE_VEC); chk("rst_busrst", bus.RESET_n, 0);
    @(negedge CLK); RESET_n = 1; #1;
    chk("busrst_hold", bus.RESET_n, 0);
    @(posedge CLK); #1;
    chk("busrst_rel", bus.RESET_n, 1);
    base = log_addr.size();
    do_req(0, 0, 16'h4000, 2, 0, lat, rd, er, ak);
    chk("t1_lat", lat, 12); chk("t1_ack", ak, 2'b01); chk("t1_rd", rd, 8'h1A); chk("t1_err", er, 0);
    chk("t1_sltexp", SLTEXP, 8'h08); chk("t1_ncyc", log_addr.size() - base, 2);
    chk("t1_sel_a", log_addr[base], 16'hFFFF); chk("t1_sel_d", log_din[base], 8'h08);
    chk("t1_sel_we", log_we[base], 1); chk("t1_acc_a", log_addr[base+1], 16'h4000);
    chk("t1_acc_we", log_we[base+1], 0); chk("t1_cs", log_cs[base+1], 4'hA);
    chk("t1_idle", bus_vec(), IDLE_VEC);
    base = log_addr.size();
    do_req(0, 0, 16'h4000, 2, 0, lat, rd, er, ak);
    chk("t2_lat", lat, 7); chk("t2_ncyc", log_addr.size() - base, 1);
    chk("t2_rd", rd, 8'h1A); chk("t2_stb_len", last_len, 3);
    base = log_addr.size();
    do_req(1, 1, 16'hFFFF, 0, 8'hA5, lat, rd, er, ak);
    chk("t3_lat", lat, 7); chk("t3_ack", ak, 2'b10); chk("t3_sltexp", SLTEXP, 8'hA5);
    chk("t3_rd", rd, 8'h00); chk("t3_ncyc", log_addr.size() - base, 1);
    chk("t3_din", log_din[base], 8'hA5); chk("t3_we", log_we[base], 1);
    base = log_addr.size();
    do_req(1, 0, 16'hC000, 2, 0, lat, rd, er, ak);
    chk("t3c_lat", lat, 7); chk("t3c_ncyc", log_addr.size() - base, 1);
    chk("t3c_addr", log_addr[base], 16'hC000); chk("t3c_cs", log_cs[base], 4'hF);
    chk("t3c_rd", rd, 8'h9A);
    do_req(0, 0, 16'hFFFF, 3, 0, lat, rd, er, ak);
    chk("t3f_lat", lat, 7); chk("t3f_rd", rd, 8'h5A); chk("t3f_sltexp", SLTEXP, 8'hA5);
    base = log_addr.size();
    @(negedge CLK); ADDR[0] = 16'h4000; SUB[0] = 2; WE[0] = 0; REQ[0] = 1;
    @(negedge CLK); REQ[0] = 0;
    seen = 0;
    repeat (20) begin @(posedge CLK); #1; seen |= ACK; end
    chk("early_ack", seen, 0); chk("early_ncyc", log_addr.size() - base, 0); chk("early_busy", BUSY, 0);
    @(negedge CLK); ADDR[1] = 16'h8000; SUB[1] = 2; WE[1] = 0; REQ[1] = 1;
    cnt = 0;
    while (!BUSY && cnt < 20) begin @(posedge CLK); #1; cnt++; end
    REQ[1] = 0;
    ak = 0; cnt = 0;
    while (ak == 0 && cnt < 50) begin @(posedge CLK); #1; cnt++; ak = ACK; end
    chk("late_ack", ak, 2'b10); chk("late_rd", RDATA, 8'hDA);
    @(negedge CLK); RESET_n = 0;
    @(negedge CLK); RESET_n = 1;
    ADDR[0] = 16'h0000; SUB[0] = 0; WE[0] = 0; ADDR[1] = 16'h1234; SUB[1] = 0; WE[1] = 0; REQ = 2'b11;
    #1 chk("rr_sltexp", SLTEXP, 0);
    for (int k = 0; k < 4; k++) begin
      ak = 0; cnt = 0;
      while (ak == 0 && cnt < 50) begin @(posedge CLK); #1; cnt++; ak = ACK; end
      chk("rr_grant", ak, k % 2 ? 2'b10 : 2'b01);
      chk("rr_rd", RDATA, k % 2 ? 8'h48 : 8'h5A);
    end
    REQ = 2'b00;
    repeat (3) @(posedge CLK);
    wait_low = 1;
    do_req(0, 0, 16'h0000, 0, 0, lat, rd, er, ak);
    chk("to_lat", lat, 261); chk("to_err", er, 1); chk("to_ack", ak, 2'b01);
    chk("to_stb_len", last_len, 258); chk("to_idle", bus_vec(), IDLE_VEC);
    repeat (40) @(posedge CLK);
    wait_low = 0;
    @(negedge CLK); ADDR[0] = 16'h4000; SUB[0] = 2; WE[0] = 0; REQ[0] = 1;
    found = 0; cnt = 0;
    while (!found && cnt < 100) begin
      @(negedge CLK); cnt++;
      found = !bus.WR_n && bus.ADDR == 16'hFFFF;
    end
    chk("mr_sel_seen", found, 1);
    #2 RESET_n = 0;
    #1;
    chk("mr_bus", bus_vec(), IDLE_VEC); chk("mr_ack", ACK, 0);
    chk("mr_busy", BUSY, 0); chk("mr_sltexp", SLTEXP, 0);
    REQ[0] = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RESET_n = 1;
    seen = 0;
    repeat (20) begin @(posedge CLK); #1; seen |= ACK; end
    chk("mr_noack", seen, 0); chk("mr_sltexp2", SLTEXP, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
